comm_master: RTL and testbench



---
 rtl/comm_pkg.sv | 23 ++
 rtl/comm_uart.sv | 171 +++++++++++++++++
 rtl/comm_master.sv | 106 ++++++++++
 tb/tb_comm_master.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// comm_pkg: shared definitions for the logic-analyzer link command master.
//   BAUD_CYCLES_DEF : default clk cycles per UART bit (115200 baud at 100 MHz)
//   tx_state_t      : two-byte command sequencer states
//   rx_state_t      : UART receiver states
package comm_pkg;

    localparam int unsigned BAUD_CYCLES_DEF = 868;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HIGH,
        TX_LOW,
        TX_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/comm_uart.sv
// comm_uart: full-duplex 8N1 UART (start 0, 8 data bits LSB first, stop 1).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   trmt, tx_data     : load tx_data and start a frame (accepted when idle or
//                       in the last cycle of the current frame)
//   tx_done           : high in the final cycle of a frame's stop bit
//   TX                : serial output, idle high
//   RX                : serial input, asynchronous, idle high
//   rx_rdy, rx_data   : received byte valid / last received byte
//   clr_rx_rdy        : clears rx_rdy (a completing frame wins)
// Build option: COMM_MASTER_FRAMING_CHK_EN rejects frames whose stop bit
// samples low.
module comm_uart
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       clr_rx_rdy
);

    localparam int unsigned   CW        = $clog2(BAUD_CYCLES);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);

    // ---------------- transmitter ----------------
    logic          tx_busy;
    logic [9:0]    tx_shift;
    logic [3:0]    tx_bit_cnt;
    logic [CW-1:0] tx_baud_cnt;
    logic          tx_bit_end;

    assign tx_bit_end = tx_busy && (tx_baud_cnt == BAUD_LAST);
    assign tx_done    = tx_bit_end && (tx_bit_cnt == 4'd9);
    // Line driven straight from a flop so reset forces it high at once.
    assign TX         = tx_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy     <= 1'b0;
            tx_shift    <= '1;
            tx_bit_cnt  <= '0;
            tx_baud_cnt <= '0;
        end else if (trmt && (!tx_busy || tx_done)) begin
            // Reload in the stop bit's last cycle gives back-to-back frames.
            tx_busy     <= 1'b1;
            tx_shift    <= {1'b1, tx_data, 1'b0};
            tx_bit_cnt  <= '0;
            tx_baud_cnt <= '0;
        end else if (tx_bit_end) begin
            tx_baud_cnt <= '0;
            tx_shift    <= {1'b1, tx_shift[9:1]};
            if (tx_done) begin
                tx_busy <= 1'b0;
            end else begin
                tx_bit_cnt <= tx_bit_cnt + 4'd1;
            end
        end else if (tx_busy) begin
            tx_baud_cnt <= tx_baud_cnt + CW'(1);
        end
    end

    // ---------------- receiver ----------------
    rx_state_t     rx_state, rx_state_nxt;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_baud_cnt;
    logic [2:0]    rx_bit_cnt;
    logic [7:0]    rx_shift;
    logic          rx_fall, rx_stop_ok;
    logic          rx_cnt_clr, rx_sample, rx_accept, rx_start;

    assign rx_fall = rx_prev && !rx_s2;

`ifdef COMM_MASTER_FRAMING_CHK_EN
    assign rx_stop_ok = rx_s2;
`else
    assign rx_stop_ok = 1'b1;
`endif

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_clr   = 1'b0;
        rx_sample    = 1'b0;
        rx_accept    = 1'b0;
        rx_start     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                // Edge (not level) detect: after a rejected stop bit the
                // line must return high before a new frame can start.
                if (rx_fall) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_clr   = 1'b1;
                    rx_start     = 1'b1;
                end
            end
            RX_START: begin
                if (rx_baud_cnt == HALF_LAST) begin
                    rx_cnt_clr   = 1'b1;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_baud_cnt == BAUD_LAST) begin
                    rx_cnt_clr = 1'b1;
                    rx_sample  = 1'b1;
                    if (rx_bit_cnt == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_baud_cnt == BAUD_LAST) begin
                    rx_state_nxt = RX_IDLE;
                    rx_accept    = rx_stop_ok;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_baud_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_rdy      <= 1'b0;
        end else begin
            rx_s1    <= RX;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_nxt;

            if (rx_cnt_clr || rx_state == RX_IDLE) begin
                rx_baud_cnt <= '0;
            end else begin
                rx_baud_cnt <= rx_baud_cnt + CW'(1);
            end

            if (rx_start) begin
                rx_bit_cnt <= '0;
            end else if (rx_sample) begin
                rx_bit_cnt <= rx_bit_cnt + 3'd1;
            end

            if (rx_sample) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
            end

            if (rx_accept) begin
                rx_data <= rx_shift;
                rx_rdy  <= 1'b1;
            end else if (clr_rx_rdy || rx_start) begin
                rx_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/comm_master.sv
// comm_master: host-side command master for the logic-analyzer link.
// Sends a 16-bit command as two back-to-back 8N1 bytes (high byte first) and
// captures single-byte responses.
// Ports:
//   clk, rst_n     : 100 MHz clock, asynchronous active-low reset
//   RX, TX         : serial response in / serial command out (idle high)
//   cmd, send_cmd  : command word and start strobe (ignored while busy)
//   cmd_sent       : level, set after the low byte's stop bit, cleared by the
//                    next accepted send_cmd
//   resp_rdy, resp : response valid flag and last received byte
//   clr_resp_rdy   : clears resp_rdy
// Build option: COMM_MASTER_FRAMING_CHK_EN (see comm_uart).
module comm_master
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    input  logic        clr_resp_rdy
);

    tx_state_t  state, state_nxt;
    // Only the low byte needs holding: the high byte is handed to the UART
    // in the same cycle the command is accepted.
    logic [7:0] cmd_lo;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       accept;
    logic       set_sent;

    always_comb begin
        state_nxt = state;
        trmt      = 1'b0;
        tx_data   = cmd[15:8];
        accept    = 1'b0;
        set_sent  = 1'b0;
        case (state)
            // DONE also accepts, so a new command is taken the cycle after
            // cmd_sent rises.
            TX_IDLE, TX_DONE: begin
                state_nxt = TX_IDLE;
                if (send_cmd) begin
                    accept    = 1'b1;
                    trmt      = 1'b1;
                    tx_data   = cmd[15:8];
                    state_nxt = TX_HIGH;
                end
            end
            TX_HIGH: begin
                if (tx_done) begin
                    trmt      = 1'b1;
                    tx_data   = cmd_lo;
                    state_nxt = TX_LOW;
                end
            end
            TX_LOW: begin
                if (tx_done) begin
                    set_sent  = 1'b1;
                    state_nxt = TX_DONE;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            cmd_lo   <= '0;
            cmd_sent <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_lo   <= cmd[7:0];
                cmd_sent <= 1'b0;
            end else if (set_sent) begin
                cmd_sent <= 1'b1;
            end
        end
    end

    comm_uart #(
        .BAUD_CYCLES(BAUD_CYCLES)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .TX         (TX),
        .RX         (RX),
        .rx_rdy     (resp_rdy),
        .rx_data    (resp),
        .clr_rx_rdy (clr_resp_rdy)
    );

endmodule

// File: tb/tb_comm_master.sv
module tb_comm_master;

    localparam int unsigned B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_line = 1'b1;
    logic        loop_en = 1'b0;
    logic        send_cmd = 1'b0;
    logic        clr_resp_rdy = 1'b0;
    logic [15:0] cmd = '0;
    logic        RX, TX, cmd_sent, resp_rdy;
    logic [7:0]  resp;

    assign RX = loop_en ? TX : rx_line;

    comm_master #(.BAUD_CYCLES(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX           (RX),
        .TX           (TX),
        .cmd          (cmd),
        .send_cmd     (send_cmd),
        .cmd_sent     (cmd_sent),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .clr_resp_rdy (clr_resp_rdy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- TX line decoder (independent of DUT internals) ----------------
    logic [7:0] tx_q[$];
    logic [7:0] mon_d;
    logic       tx_prev = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_prev && !TX) begin
                repeat (B/2) @(negedge clk);
                if (!TX) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (B) @(negedge clk);
                        mon_d[i] = TX;
                    end
                    repeat (B) @(negedge clk);
                    tx_q.push_back(mon_d);
                end
            end
            tx_prev = TX;
        end
    end

    function automatic logic [7:0] pop_tx();
        if (tx_q.size() == 0) return 8'hxx;
        return tx_q.pop_front();
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  rsp;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_resp;
    } vec_t;

    function automatic vec_t model(input logic [15:0] c, input logic [7:0] r);
        vec_t v;
        int unsigned ci;
        ci         = int'(c);
        v.cmd      = c;
        v.rsp      = r;
        v.exp_hi   = 8'(ci / 256);
        v.exp_lo   = 8'(ci % 256);
        v.exp_resp = r;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] c);
        @(negedge clk);
        cmd      = c;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        cmd      = 16'($urandom);
        check("cmd_sent_cleared", cmd_sent, 1'b0);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            repeat (B) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic wait_cmd_sent(input int limit);
        int n = 0;
        while (!cmd_sent && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("cmd_sent_seen", cmd_sent, 1'b1);
    endtask

    task automatic wait_resp_rdy(input int limit);
        int n = 0;
        while (!resp_rdy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("resp_rdy_seen", resp_rdy, 1'b1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int rx_delay);
        tx_q.delete();
        fork
            send(v.cmd);
            begin
                repeat (rx_delay) @(negedge clk);
                drive_rx(v.rsp, 1'b1);
            end
        join
        wait_cmd_sent(25*B);
        wait_resp_rdy(30*B);
        check("tx_byte_count", tx_q.size(), 2);
        check("tx_hi", pop_tx(), v.exp_hi);
        check("tx_lo", pop_tx(), v.exp_lo);
        check("resp", resp, v.exp_resp);
        pulse_clr();
        check("resp_rdy_after_clr", resp_rdy, 1'b0);
        check("resp_hold_after_clr", resp, v.exp_resp);
    endtask

    vec_t       vecs[5];
    logic       wave[20*B];
    logic [B-1:0] bitv;
    logic [9:0] frame;
    logic [7:0] byt;
    logic [7:0] got[$];
    int         hi_cycles, lat, rises;
    logic       prev_rdy;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h4016, 8'hA5, 8'h40, 8'h16, 8'hA5};
        vecs[1] = '{16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{16'h8001, 8'h5A, 8'h80, 8'h01, 8'h5A};
        vecs[4] = '{16'h1234, 8'h3C, 8'h12, 8'h34, 8'h3C};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_TX", TX, 1'b1);
        check("rst_cmd_sent", cmd_sent, 1'b0);
        check("rst_resp_rdy", resp_rdy, 1'b0);
        check("rst_resp", resp, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // exact bit-level waveform and cmd_sent timing
        cmd      = 16'h4016;
        send_cmd = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 20*B; j++) begin
            @(negedge clk);
            if (j == 0) send_cmd = 1'b0;
            if (j < 20*B) wave[j] = TX;
            if (j == 20*B - 1) check("cmd_sent_not_early", cmd_sent, 1'b0);
            if (j == 20*B) check("cmd_sent_at_321", cmd_sent, 1'b1);
        end
        for (int b = 0; b < 20; b++) begin
            byt   = (b < 10) ? 8'h40 : 8'h16;
            frame = {1'b1, byt, 1'b0};
            for (int k = 0; k < B; k++) bitv[k] = wave[b*B + k];
            check($sformatf("tx_bit%0d", b), bitv, {B{frame[b % 10]}});
        end
        repeat (3*B) @(negedge clk);
        check("cmd_sent_holds", cmd_sent, 1'b1);
        check("tx_idle_high", TX, 1'b1);

        // busy ignore
        tx_q.delete();
        send(16'h4016);
        repeat (40) @(negedge clk);
        cmd      = 16'hFFFF;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        wait_cmd_sent(25*B);
        repeat (2) @(negedge clk);
        check("busy_byte_count", tx_q.size(), 2);
        check("busy_hi", pop_tx(), 8'h40);
        check("busy_lo", pop_tx(), 8'h16);

        // table-driven vectors, RX overlapping TX
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i * (B/2 + 3));

        // randomized commands/responses against the model
        for (int i = 0; i < 8; i++)
            run_vec(model(16'($urandom), 8'($urandom)), int'($urandom_range(0, 12*B)));

        // completion and clear in the same cycle: set wins
        clr_resp_rdy = 1'b1;
        hi_cycles    = 0;
        fork
            drive_rx(8'h3C, 1'b1);
            repeat (12*B) begin
                @(negedge clk);
                if (resp_rdy) hi_cycles++;
            end
        join
        clr_resp_rdy = 1'b0;
        check("set_wins_cycles", hi_cycles, 1);
        check("set_wins_resp", resp, 8'h3C);

        // receive latency
        lat = 0;
        fork
            drive_rx(8'h81, 1'b1);
            begin
                @(negedge clk);
                while (!resp_rdy && lat < 20*B) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("rx_latency_window", (lat >= 153 && lat <= 155), 1'b1);
        check("rx_latency_resp", resp, 8'h81);
        pulse_clr();

        // 3-cycle glitch is rejected
        @(negedge clk);
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (12*B) @(negedge clk);
        check("glitch_no_rdy", resp_rdy, 1'b0);
        check("glitch_resp_kept", resp, 8'h81);

        // stop bit low
        drive_rx(8'hEE, 1'b0);
        repeat (2*B) @(negedge clk);
`ifdef COMM_MASTER_FRAMING_CHK_EN
        check("framing_no_rdy", resp_rdy, 1'b0);
        check("framing_resp_kept", resp, 8'h81);
`else
        check("framing_ignored_rdy", resp_rdy, 1'b1);
        check("framing_ignored_resp", resp, 8'hEE);
`endif
        pulse_clr();
        drive_rx(8'h5A, 1'b1);
        repeat (B) @(negedge clk);
        check("rearm_rdy", resp_rdy, 1'b1);
        check("rearm_resp", resp, 8'h5A);
        pulse_clr();

        // loopback
        loop_en = 1'b1;
        got.delete();
        rises    = 0;
        prev_rdy = 1'b0;
        fork
            send(16'h1234);
            repeat (22*B) begin
                @(negedge clk);
                if (resp_rdy && !prev_rdy) begin
                    rises++;
                    got.push_back(resp);
                end
                prev_rdy = resp_rdy;
            end
        join
        loop_en = 1'b0;
        check("loop_rises", rises, 2);
        check("loop_first", (got.size() > 0) ? got[0] : 8'hxx, 8'h12);
        check("loop_second", (got.size() > 1) ? got[1] : 8'hxx, 8'h34);
        check("loop_cmd_sent", cmd_sent, 1'b1);
        pulse_clr();

        // asynchronous reset mid-frame
        fork
            send(16'h0F0F);
            drive_rx(8'hFF, 1'b1);
            begin
                repeat (5*B) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_TX", TX, 1'b1);
                check("async_rst_cmd_sent", cmd_sent, 1'b0);
                check("async_rst_resp", resp, 8'h00);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (12*B) @(negedge clk);
        check("post_rst_resp_rdy", resp_rdy, 1'b0);
        check("post_rst_cmd_sent", cmd_sent, 1'b0);
        check("post_rst_TX", TX, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
